// File: rtl/imem_byte_arbiter.sv
`default_nettype none
// ============================================================================
// imem_byte_arbiter : round-robin IF/DM arbiter that turns each 32-bit access
// into four big-endian byte beats on a shared synchronous-read byte RAM.
// Revision 1.0
// ============================================================================
module imem_byte_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_done,
    output logic [31:0]       dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DRAIN  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state_q;
    logic [1:0]        beat_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wshift_q;
    logic [23:0]       rbuf_q;
    logic              if_done_q;
    logic              dm_done_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       dm_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              busy_q;

    logic              grant_dm_d;
    logic              we_d;
    logic [ADDR_W-1:0] base_d;
    logic [31:0]       wdata_d;
    logic [1:0]        beat_d;
    logic              unused_addr_bits;

    // On a tie the requester that did not win last time is served.
    assign grant_dm_d = dm_req && (!if_req || !owner_q);
    assign we_d       = grant_dm_d && dm_we;
    assign base_d     = grant_dm_d ? dm_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
    assign wdata_d    = grant_dm_d ? dm_wdata : 32'h0;
    assign beat_d     = beat_q + 2'd1;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beat_q      <= 2'd0;
            owner_q     <= 1'b1;
            we_q        <= 1'b0;
            base_q      <= '0;
            wshift_q    <= 32'h0;
            rbuf_q      <= 24'h0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h0;
            busy_q      <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (if_req || dm_req) begin
                        owner_q     <= grant_dm_d;
                        we_q        <= we_d;
                        base_q      <= base_d;
                        wshift_q    <= {wdata_d[23:0], 8'h0};
                        beat_q      <= 2'd0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= we_d;
                        mem_addr_q  <= base_d;
                        mem_wdata_q <= wdata_d[31:24];
                        busy_q      <= 1'b1;
                        state_q     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Read data lags its beat by one cycle, so beat k returns byte k-1.
                    if (beat_q != 2'd0 && !we_q) begin
                        rbuf_q <= {rbuf_q[15:0], mem_rdata};
                    end
                    if (beat_q == 2'd3) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (we_q) begin
                            if_done_q <= !owner_q;
                            dm_done_q <= owner_q;
                            state_q   <= S_RESP;
                        end else begin
                            state_q   <= S_DRAIN;
                        end
                    end else begin
                        beat_q      <= beat_d;
                        mem_addr_q  <= base_q + ADDR_W'(beat_d);
                        mem_wdata_q <= wshift_q[31:24];
                        wshift_q    <= {wshift_q[23:0], 8'h0};
                    end
                end
                S_DRAIN: begin
                    if (owner_q) begin
                        dm_rdata_q <= {rbuf_q, mem_rdata};
                        dm_done_q  <= 1'b1;
                    end else begin
                        if_rdata_q <= {rbuf_q, mem_rdata};
                        if_done_q  <= 1'b1;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    beat_q  <= 2'd0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule
`default_nettype wire
